// File: rtl/rs_pkg.sv
// Shared types for the reservation station: tag/payload widths, the entry
// record and field offsets inside the opaque control payload.
package rs_pkg;

  localparam int RS_TAG_W = 4;
  localparam int RS_PAY_W = 82;

  typedef logic [RS_TAG_W-1:0] tag_t;
  typedef logic [RS_PAY_W-1:0] payload_t;

  // Payload layout as packed by decode; the station never looks inside it.
  localparam int PAY_PCPLUS4_LSB  = 0;
  localparam int PAY_EXTIMM_LSB   = 32;
  localparam int PAY_FLAGS_LSB    = 64;
  localparam int PAY_ALUCTL_LSB   = 70;
  localparam int PAY_WRITEREG_LSB = 74;

  typedef struct packed {
    logic        valid;
    tag_t        tag;
    logic [31:0] src1;
    logic        src1_v;
    logic [31:0] src2;
    logic        src2_v;
    payload_t    payload;
  } rs_entry_t;

endpackage

// File: rtl/rs_station_if.sv
// Dispatch, result-broadcast, flush and issue signals of one reservation station.
interface rs_station_if
  import rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = RS_TAG_W,
  parameter int NUM_CDB = 3,
  parameter int PAY_W   = RS_PAY_W
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic                     disp_valid;
  logic                     disp_ready;
  logic [TAG_W-1:0]         disp_tag;
  logic [31:0]              disp_src1;
  logic [31:0]              disp_src2;
  logic                     disp_src1_v;
  logic                     disp_src2_v;
  logic [PAY_W-1:0]         disp_payload;
  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag;
  logic [NUM_CDB*32-1:0]    cdb_data;
  logic                     flush;
  logic                     iss_valid;
  logic                     iss_ready;
  logic [TAG_W-1:0]         iss_tag;
  logic [31:0]              iss_op1;
  logic [31:0]              iss_op2;
  logic [PAY_W-1:0]         iss_payload;
  logic [OCC_W-1:0]         occupancy;

  modport master (
    output disp_valid, disp_tag, disp_src1, disp_src2, disp_src1_v, disp_src2_v,
           disp_payload, cdb_valid, cdb_tag, cdb_data, flush, iss_ready,
    input  disp_ready, iss_valid, iss_tag, iss_op1, iss_op2, iss_payload, occupancy
  );

  modport slave (
    input  disp_valid, disp_tag, disp_src1, disp_src2, disp_src1_v, disp_src2_v,
           disp_payload, cdb_valid, cdb_tag, cdb_data, flush, iss_ready,
    output disp_ready, iss_valid, iss_tag, iss_op1, iss_op2, iss_payload, occupancy
  );

endinterface

// File: rtl/rs_age_select.sv
// Age matrix for the station: older[i][j]=1 means entry i was dispatched before j.
// Grants the single oldest ready entry.
module rs_age_select #(
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [DEPTH-1:0] alloc,
  input  logic             flush,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant,
  output logic             grant_valid
);

  logic [DEPTH-1:0] older [DEPTH];

  // A new entry is younger than everything present; stale rows of free
  // entries are rewritten when those entries are allocated again.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          older[i] <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != i) older[j][i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] && !older[i][j]) grant[i] = 1'b0;
      end
    end
  end

  assign grant_valid = |ready;

endmodule

// File: rtl/rs_station.sv
// Reservation station: CDB wakeup, oldest-ready issue, flush. TAG_W/PAY_W track rs_pkg.
// RS_DISP_SNOOP_EN: compare dispatching pending operands against the same-cycle CDB.
module rs_station
  import rs_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = RS_TAG_W,
  parameter int NUM_CDB = 3,
  parameter int PAY_W   = RS_PAY_W
) (
  input logic         CLK,
  input logic         reset,
  rs_station_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  rs_entry_t        ent [DEPTH];
  logic [DEPTH-1:0] ready_vec, free_oh, alloc_oh, grant;
  logic             any_ready, found, disp_fire, iss_fire;
  logic [OCC_W-1:0] occ;
  logic [31:0]      d_src1, d_src2;
  logic             d_src1_v, d_src2_v;
  logic [TAG_W-1:0] iss_tag;
  logic [31:0]      iss_op1, iss_op2;
  logic [PAY_W-1:0] iss_payload;

  always_comb begin
    occ     = '0;
    free_oh = '0;
    found   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = ent[i].valid & ent[i].src1_v & ent[i].src2_v;
      occ = occ + OCC_W'(ent[i].valid);
      if (!ent[i].valid && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign bus.occupancy  = occ;
  assign bus.disp_ready = (occ != OCC_W'(DEPTH));
  assign disp_fire      = bus.disp_valid & bus.disp_ready & ~bus.flush;
  assign alloc_oh       = disp_fire ? free_oh : '0;

`ifdef RS_DISP_SNOOP_EN
  // Descending channel loop so the lowest matching channel is the last write.
  always_comb begin
    d_src1   = bus.disp_src1;
    d_src1_v = bus.disp_src1_v;
    d_src2   = bus.disp_src2;
    d_src2_v = bus.disp_src2_v;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (bus.cdb_valid[c] && !bus.disp_src1_v &&
          bus.cdb_tag[c*TAG_W +: TAG_W] == bus.disp_src1[TAG_W-1:0]) begin
        d_src1   = bus.cdb_data[c*32 +: 32];
        d_src1_v = 1'b1;
      end
      if (bus.cdb_valid[c] && !bus.disp_src2_v &&
          bus.cdb_tag[c*TAG_W +: TAG_W] == bus.disp_src2[TAG_W-1:0]) begin
        d_src2   = bus.cdb_data[c*32 +: 32];
        d_src2_v = 1'b1;
      end
    end
  end
`else
  assign d_src1   = bus.disp_src1;
  assign d_src1_v = bus.disp_src1_v;
  assign d_src2   = bus.disp_src2;
  assign d_src2_v = bus.disp_src2_v;
`endif

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .CLK        (CLK),
    .reset      (reset),
    .alloc      (alloc_oh),
    .flush      (bus.flush),
    .ready      (ready_vec),
    .grant      (grant),
    .grant_valid(any_ready)
  );

  assign bus.iss_valid = any_ready & ~bus.flush;
  assign iss_fire      = bus.iss_valid & bus.iss_ready;

  always_comb begin
    iss_tag     = '0;
    iss_op1     = '0;
    iss_op2     = '0;
    iss_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i] && bus.iss_valid) begin
        iss_tag     = iss_tag | ent[i].tag;
        iss_op1     = iss_op1 | ent[i].src1;
        iss_op2     = iss_op2 | ent[i].src2;
        iss_payload = iss_payload | ent[i].payload;
      end
    end
  end

  assign bus.iss_tag     = iss_tag;
  assign bus.iss_op1     = iss_op1;
  assign bus.iss_op2     = iss_op2;
  assign bus.iss_payload = iss_payload;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.flush) begin
          ent[i].valid <= 1'b0;
        end else if (alloc_oh[i]) begin
          ent[i] <= '{valid: 1'b1, tag: bus.disp_tag, src1: d_src1, src1_v: d_src1_v,
                      src2: d_src2, src2_v: d_src2_v, payload: bus.disp_payload};
        end else if (ent[i].valid) begin
          if (iss_fire && grant[i]) begin
            ent[i].valid <= 1'b0;
          end else begin
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
              if (!ent[i].src1_v && bus.cdb_valid[c] &&
                  bus.cdb_tag[c*TAG_W +: TAG_W] == ent[i].src1[TAG_W-1:0]) begin
                ent[i].src1   <= bus.cdb_data[c*32 +: 32];
                ent[i].src1_v <= 1'b1;
              end
              if (!ent[i].src2_v && bus.cdb_valid[c] &&
                  bus.cdb_tag[c*TAG_W +: TAG_W] == ent[i].src2[TAG_W-1:0]) begin
                ent[i].src2   <= bus.cdb_data[c*32 +: 32];
                ent[i].src2_v <= 1'b1;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus random traffic against a
// dispatch-ordered queue model. Honours RS_DISP_SNOOP_EN like the design.
module tb_rs_station;
  import rs_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int NUM_CDB = 3;
  localparam int PAY_W   = 82;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  rs_station_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .PAY_W(PAY_W)) bus ();

  rs_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .PAY_W(PAY_W)) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      s1, s2;
    bit               v1, v2;
    logic [PAY_W-1:0] pay;
  } m_ent_t;

  m_ent_t q[$];

  task automatic idle_inputs();
    bus.disp_valid = 0; bus.disp_tag = '0; bus.disp_src1 = '0; bus.disp_src2 = '0;
    bus.disp_src1_v = 0; bus.disp_src2_v = 0; bus.disp_payload = '0;
    bus.cdb_valid = '0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.flush = 0;
  endtask

  task automatic put_disp(input logic [TAG_W-1:0] t, input logic [31:0] a, input bit av,
                          input logic [31:0] b, input bit bv, input logic [PAY_W-1:0] p);
    bus.disp_valid = 1; bus.disp_tag = t; bus.disp_src1 = a; bus.disp_src1_v = av;
    bus.disp_src2 = b; bus.disp_src2_v = bv; bus.disp_payload = p;
  endtask

  task automatic put_cdb(input int c, input logic [TAG_W-1:0] t, input logic [31:0] d);
    bus.cdb_valid[c] = 1'b1;
    bus.cdb_tag[c*TAG_W +: TAG_W] = t;
    bus.cdb_data[c*32 +: 32] = d;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.iss_ready = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    q.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.iss_ready = 0;
    reset = 1;
    repeat (2) @(negedge CLK);
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2, bus.iss_payload}
        !== {3'd0, 1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 82'd0}) begin
      n_err++;
      $display("FAIL reset_state: occ=%0d rdy=%0b iv=%0b tag=%0h op1=%0h op2=%0h, need 0/1/0/0/0/0",
               bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2);
    end
    reset = 0;
    @(negedge CLK);
    put_disp(4'd3, 32'd5, 1, 32'd7, 1, '0);
    step();
    bus.disp_valid = 0;
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.iss_valid} !== {3'd1, 1'b1}) begin
      n_err++;
      $display("FAIL pre_async_reset: occ=%0d iv=%0b, need 1/1", bus.occupancy, bus.iss_valid);
    end
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag} !== {3'd0, 1'b1, 1'b0, 4'd0}) begin
      n_err++;
      $display("FAIL async_reset: occ=%0d rdy=%0b iv=%0b tag=%0h, need 0/1/0/0",
               bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag);
    end
    reset = 0;
    @(negedge CLK);
  endtask

  task automatic test_ready_dispatch();
    logic [PAY_W-1:0] p1;
    p1 = {18'h2ABCD, 32'hDEADBEEF, 32'h01234567};
    do_reset();
    bus.iss_ready = 1;
    put_disp(4'd3, 32'd5, 1, 32'd7, 1, p1);
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.disp_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL no_passthrough: iv=%0b rdy=%0b, need 0/1", bus.iss_valid, bus.disp_ready);
    end
    step();
    bus.disp_valid = 0;
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2, bus.iss_payload, bus.occupancy}
        !== {1'b1, 4'd3, 32'd5, 32'd7, p1, 3'd1}) begin
      n_err++;
      $display("FAIL ready_issue: iv=%0b tag=%0h op1=%0h op2=%0h pay=%0h occ=%0d, need 1/3/5/7/%0h/1",
               bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2, bus.iss_payload, bus.occupancy, p1);
    end
    step();
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.iss_valid, bus.iss_tag, bus.iss_op1} !== {3'd0, 1'b0, 4'd0, 32'd0}) begin
      n_err++;
      $display("FAIL ready_drain: occ=%0d iv=%0b tag=%0h op1=%0h, need 0/0/0/0",
               bus.occupancy, bus.iss_valid, bus.iss_tag, bus.iss_op1);
    end
  endtask

  task automatic test_wakeup();
    do_reset();
    bus.iss_ready = 1;
    put_disp(4'd2, 32'h9, 0, 32'h1, 1, '0);
    step();
    bus.disp_valid = 0;
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.occupancy} !== {1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL wake_pending: iv=%0b occ=%0d, need 0/1", bus.iss_valid, bus.occupancy);
    end
    put_cdb(0, 4'd5, 32'h99);
    put_cdb(1, 4'd9, 32'h1234);
    put_cdb(2, 4'd9, 32'hDEAD);
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wake_same_cycle: iv=%0b, need 0", bus.iss_valid);
    end
    step();
    bus.cdb_valid = '0;
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2} !== {1'b1, 4'd2, 32'h1234, 32'h1}) begin
      n_err++;
      $display("FAIL wake_issue: iv=%0b tag=%0h op1=%0h op2=%0h, need 1/2/1234/1",
               bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2);
    end
    step();
  endtask

  task automatic test_full_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put_disp(4'(4 + i), 32'(i), 1, 32'(i + 100), 1, '0);
      #1;
      n_cmp++;
      if (bus.disp_ready !== (i < 4)) begin
        n_err++;
        $display("FAIL full_ready[%0d]: rdy=%0b, need %0b", i, bus.disp_ready, (i < 4));
      end
      step();
    end
    bus.iss_ready = 1;
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag} !== {3'd4, 1'b0, 1'b1, 4'd4}) begin
      n_err++;
      $display("FAIL full_issue: occ=%0d rdy=%0b iv=%0b tag=%0h, need 4/0/1/4",
               bus.occupancy, bus.disp_ready, bus.iss_valid, bus.iss_tag);
    end
    step();
    #1;
    n_cmp++;
    if ({bus.occupancy, bus.disp_ready, bus.iss_tag} !== {3'd3, 1'b1, 4'd5}) begin
      n_err++;
      $display("FAIL full_reuse: occ=%0d rdy=%0b tag=%0h, need 3/1/5", bus.occupancy, bus.disp_ready, bus.iss_tag);
    end
    step();
    bus.disp_valid = 0;
    for (int t = 6; t <= 8; t++) begin
      #1;
      n_cmp++;
      if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 4'(t)}) begin
        n_err++;
        $display("FAIL full_drain_order: iv=%0b tag=%0h, need 1/%0h", bus.iss_valid, bus.iss_tag, t);
      end
      step();
    end
    #1;
    n_cmp++;
    if (bus.occupancy !== 3'd0) begin
      n_err++;
      $display("FAIL full_empty: occ=%0d, need 0", bus.occupancy);
    end
  endtask

  task automatic test_age_order();
    do_reset();
    bus.iss_ready = 1;
    put_disp(4'd1, 32'h1, 1, 32'h2, 1, '0);
    step();
    put_disp(4'd10, 32'd12, 0, 32'h20, 1, '0);
    step();
    put_disp(4'd11, 32'h30, 1, 32'h31, 1, '0);
    #1;
    n_cmp++;
    if (bus.iss_valid !== 1'b0) begin
      n_err++;
      $display("FAIL age_pending_only: iv=%0b, need 0", bus.iss_valid);
    end
    step();
    bus.disp_valid = 0;
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.iss_tag} !== {1'b1, 4'd11}) begin
      n_err++;
      $display("FAIL age_ready_first: iv=%0b tag=%0h, need 1/b", bus.iss_valid, bus.iss_tag);
    end
    step();
    put_disp(4'd13, 32'h40, 1, 32'h41, 1, '0);
    put_cdb(0, 4'd12, 32'h55);
    step();
    idle_inputs();
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2} !== {1'b1, 4'd10, 32'h55, 32'h20}) begin
      n_err++;
      $display("FAIL age_older_woken: iv=%0b tag=%0h op1=%0h op2=%0h, need 1/a/55/20",
               bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2);
    end
    step();
    #1;
    n_cmp++;
    if ({bus.iss_tag, bus.iss_op1} !== {4'd13, 32'h40}) begin
      n_err++;
      $display("FAIL age_younger_last: tag=%0h op1=%0h, need d/40", bus.iss_tag, bus.iss_op1);
    end
    step();
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      put_disp(4'(1 + i), 32'(i), 1, 32'(i), 1, '0);
      step();
    end
    put_disp(4'd14, 32'h1, 1, 32'h2, 1, '0);
    bus.flush = 1;
    #1;
    n_cmp++;
    if ({bus.iss_valid, bus.occupancy} !== {1'b0, 3'd3}) begin
      n_err++;
      $display("FAIL flush_cycle: iv=%0b occ=%0d, need 0/3", bus.iss_valid, bus.occupancy);
    end
    step();
    idle_inputs();
    bus.iss_ready = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if ({bus.occupancy, bus.iss_valid, bus.disp_ready} !== {3'd0, 1'b0, 1'b1}) begin
        n_err++;
        $display("FAIL flush_after[%0d]: occ=%0d iv=%0b rdy=%0b, need 0/0/1",
                 k, bus.occupancy, bus.iss_valid, bus.disp_ready);
      end
      step();
    end
  endtask

  task automatic test_snoop();
    do_reset();
    bus.iss_ready = 1;
    put_disp(4'd5, 32'h11, 1, 32'h6, 0, '0);
    put_cdb(0, 4'd6, 32'hABCD);
    step();
    idle_inputs();
    #1;
    n_cmp++;
`ifdef RS_DISP_SNOOP_EN
    if ({bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2} !== {1'b1, 4'd5, 32'h11, 32'hABCD}) begin
      n_err++;
      $display("FAIL snoop_capture: iv=%0b tag=%0h op1=%0h op2=%0h, need 1/5/11/abcd",
               bus.iss_valid, bus.iss_tag, bus.iss_op1, bus.iss_op2);
    end
`else
    if ({bus.iss_valid, bus.occupancy} !== {1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL snoop_absent: iv=%0b occ=%0d, need 0/1", bus.iss_valid, bus.occupancy);
    end
`endif
    step();
  endtask

  task automatic wake_model(inout m_ent_t e);
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!e.v1 && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == e.s1[TAG_W-1:0]) begin
        e.s1 = bus.cdb_data[c*32 +: 32];
        e.v1 = 1;
      end
    end
    for (int c = 0; c < NUM_CDB; c++) begin
      if (!e.v2 && bus.cdb_valid[c] && bus.cdb_tag[c*TAG_W +: TAG_W] == e.s2[TAG_W-1:0]) begin
        e.s2 = bus.cdb_data[c*32 +: 32];
        e.v2 = 1;
      end
    end
  endtask

  task automatic test_random();
    int     exp_idx;
    bit     exp_rdy, accept, fire;
    m_ent_t e;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      bus.disp_valid   = ($urandom_range(0, 99) < 60);
      bus.disp_tag     = 4'($urandom);
      bus.disp_src1    = $urandom & 32'hFFFF_FFF3;
      bus.disp_src2    = $urandom & 32'hFFFF_FFF3;
      bus.disp_src1_v  = 1'($urandom_range(0, 1));
      bus.disp_src2_v  = 1'($urandom_range(0, 1));
      bus.disp_payload = {18'($urandom), $urandom, $urandom};
      for (int c = 0; c < NUM_CDB; c++) begin
        bus.cdb_valid[c] = ($urandom_range(0, 99) < 40);
        bus.cdb_tag[c*TAG_W +: TAG_W] = 4'($urandom_range(0, 3));
        bus.cdb_data[c*32 +: 32] = $urandom;
      end
      bus.flush     = ($urandom_range(0, 99) < 3);
      bus.iss_ready = ($urandom_range(0, 99) < 70);

      exp_idx = -1;
      if (!bus.flush) begin
        for (int k = 0; k < q.size(); k++) begin
          if (exp_idx < 0 && q[k].v1 && q[k].v2) exp_idx = k;
        end
      end
      exp_rdy = (q.size() != DEPTH);
      #1;
      n_cmp++;
      if ({bus.disp_ready, bus.occupancy, bus.iss_valid} !== {exp_rdy, 3'(q.size()), (exp_idx >= 0)}) begin
        n_err++;
        $display("FAIL rand_status[%0d]: rdy=%0b occ=%0d iv=%0b, need %0b/%0d/%0b",
                 cyc, bus.disp_ready, bus.occupancy, bus.iss_valid, exp_rdy, q.size(), (exp_idx >= 0));
      end
      n_cmp++;
      if (exp_idx >= 0) begin
        if ({bus.iss_tag, bus.iss_op1, bus.iss_op2, bus.iss_payload}
            !== {q[exp_idx].tag, q[exp_idx].s1, q[exp_idx].s2, q[exp_idx].pay}) begin
          n_err++;
          $display("FAIL rand_issue[%0d]: tag=%0h op1=%0h op2=%0h, need %0h/%0h/%0h",
                   cyc, bus.iss_tag, bus.iss_op1, bus.iss_op2, q[exp_idx].tag, q[exp_idx].s1, q[exp_idx].s2);
        end
      end else if ({bus.iss_tag, bus.iss_op1, bus.iss_op2, bus.iss_payload} !== '0) begin
        n_err++;
        $display("FAIL rand_idle_zero[%0d]: tag=%0h op1=%0h op2=%0h, need all 0",
                 cyc, bus.iss_tag, bus.iss_op1, bus.iss_op2);
      end

      accept = bus.disp_valid && exp_rdy && !bus.flush;
      fire   = (exp_idx >= 0) && bus.iss_ready;
      @(posedge CLK);
      if (bus.flush) begin
        q.delete();
      end else begin
        if (fire) q.delete(exp_idx);
        for (int k = 0; k < q.size(); k++) begin
          e = q[k];
          wake_model(e);
          q[k] = e;
        end
        if (accept) begin
          e.tag = bus.disp_tag; e.pay = bus.disp_payload;
          e.s1 = bus.disp_src1; e.v1 = bus.disp_src1_v;
          e.s2 = bus.disp_src2; e.v2 = bus.disp_src2_v;
`ifdef RS_DISP_SNOOP_EN
          wake_model(e);
`endif
          q.push_back(e);
        end
      end
      @(negedge CLK);
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.iss_ready = 0;
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_full_backpressure();
    test_age_order();
    test_flush();
    test_snoop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
